// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register with operand forwarding,
// load-use hazard detection, backpressure hold and flush.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs_data,
   input  logic [31:0] in_rt_data,
   input  logic [15:0] in_imm,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [3:0]  in_alu_op,
   input  logic        in_alu_src,
   input  logic        in_reg_dst,
   input  logic        in_reg_write,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        in_mem_to_reg,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic [31:0] store_data,
   output logic [4:0]  dest_reg,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_mem_to_reg,
   output logic [15:0] stall_cnt
);
   logic        r_valid;
   logic [31:0] r_rs_data, r_rt_data, r_imm;
   logic [4:0]  r_rs, r_rt, r_dest;
   logic [3:0]  r_alu_op;
   logic        r_alu_src, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
   logic [15:0] r_stall_cnt;
   logic        w_hazard, w_capture;
   logic [31:0] w_fwd_rs, w_fwd_rt;

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data);
      return (exmem_reg_write && exmem_rd == idx && idx != 5'd0) ? exmem_result :
             (memwb_reg_write && memwb_rd == idx && idx != 5'd0) ? memwb_result : data;
   endfunction

   assign w_fwd_rs  = fwd(r_rs, r_rs_data);
   assign w_fwd_rt  = fwd(r_rt, r_rt_data);
   assign w_hazard  = in_valid & r_valid & r_mem_read & (r_dest != 5'd0) &
                      ((r_dest == in_rs) | (r_dest == in_rt));
   assign in_ready  = ~rst & ~w_hazard & (~r_valid | out_ready) & ~flush;
   assign w_capture = in_valid & in_ready;

   assign out_valid      = r_valid;
   assign alu_a          = w_fwd_rs;
   assign alu_b          = r_alu_src ? r_imm : w_fwd_rt;
   assign store_data     = w_fwd_rt;
   assign alu_op         = r_alu_op;
   assign dest_reg       = r_dest;
   assign out_reg_write  = r_valid & r_reg_write;
   assign out_mem_read   = r_valid & r_mem_read;
   assign out_mem_write  = r_valid & r_mem_write;
   assign out_mem_to_reg = r_valid & r_mem_to_reg;
   assign stall_cnt      = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_dest       <= '0;
         r_alu_op     <= '0;
         r_alu_src    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_hazard && !flush && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (flush)
            r_valid <= 1'b0;
         else if (w_capture) begin
            r_valid      <= 1'b1;
            r_rs_data    <= in_rs_data;
            r_rt_data    <= in_rt_data;
            r_imm        <= {{16{in_imm[15]}}, in_imm};
            r_rs         <= in_rs;
            r_rt         <= in_rt;
            r_dest       <= in_reg_dst ? in_rd : in_rt;
            r_alu_op     <= in_alu_op;
            r_alu_src    <= in_alu_src;
            r_reg_write  <= in_reg_write;
            r_mem_read   <= in_mem_read;
            r_mem_write  <= in_mem_write;
            r_mem_to_reg <= in_mem_to_reg;
         end else if (r_valid && !out_ready) begin
            // refresh operands so a producer retiring mid-stall is kept
            r_rs_data <= w_fwd_rs;
            r_rt_data <= w_fwd_rt;
         end else
            r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
   logic        clk, rst, in_valid, in_ready;
   logic [31:0] in_rs_data, in_rt_data;
   logic [15:0] in_imm;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [3:0]  in_alu_op;
   logic        in_alu_src, in_reg_dst, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write, flush, out_valid, out_ready;
   logic [4:0]  exmem_rd, memwb_rd, dest_reg;
   logic [31:0] exmem_result, memwb_result, alu_a, alu_b, store_data;
   logic [3:0]  alu_op;
   logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
   logic [15:0] stall_cnt;
   int checks = 0;
   int failures = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu_op(in_alu_op),
      .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
      .dest_reg(dest_reg), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      in_valid = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
      in_rs = 0; in_rt = 0; in_rd = 0; in_alu_op = 0;
      in_alu_src = 0; in_reg_dst = 0; in_reg_write = 0;
      in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
      flush = 0; out_ready = 1;
   endtask

   initial begin
      clr();
      rst = 1;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_reg_write", out_reg_write, 0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      // ADD capture
      in_valid = 1; in_rs = 1; in_rs_data = 5; in_rt = 2; in_rt_data = 7;
      in_rd = 3; in_reg_dst = 1; in_alu_op = 4'b0010; in_reg_write = 1;
      tick();
      clr();
      chk("add_out_valid", out_valid, 1);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_b", alu_b, 7);
      chk("add_alu_op", alu_op, 4'b0010);
      chk("add_dest", dest_reg, 3);
      chk("add_reg_write", out_reg_write, 1);
      tick();
      chk("drain_out_valid", out_valid, 0);
      chk("drain_reg_write_gated", out_reg_write, 0);
      chk("drain_alu_a_held", alu_a, 5);
      // immediate
      in_valid = 1; in_alu_src = 1; in_imm = 16'hFFFC; in_rs = 1; in_rs_data = 5; in_rt = 2;
      tick();
      clr();
      chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
      chk("imm_dest_rt", dest_reg, 2);
      tick();
      // forwarding priority
      in_valid = 1; in_rs = 3; in_rs_data = 32'h11; in_alu_op = 4'b0010;
      tick();
      clr();
      out_ready = 0;
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
      #1;
      chk("fwd_exmem_prio", alu_a, 32'hAA);
      exmem_rd = 0;
      #1;
      chk("fwd_memwb", alu_a, 32'hBB);
      clr();
      in_valid = 1; in_rs = 0; in_rs_data = 32'h22;
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBB;
      tick();
      in_valid = 0;
      chk("fwd_r0_stored", alu_a, 32'h22);
      clr();
      tick();
      // load-use bubble
      in_valid = 1; in_mem_read = 1; in_rt = 4; in_reg_write = 1; in_mem_to_reg = 1;
      tick();
      clr();
      chk("lw_mem_read", out_mem_read, 1);
      chk("lw_dest", dest_reg, 4);
      in_valid = 1; in_rs = 4; in_rs_data = 9; in_rt = 5; in_rd = 6; in_reg_dst = 1;
      #1;
      chk("hazard_in_ready", in_ready, 0);
      tick();
      chk("bubble_out_valid", out_valid, 0);
      chk("bubble_stall_cnt", stall_cnt, 1);
      chk("bubble_in_ready", in_ready, 1);
      tick();
      clr();
      chk("after_bubble_valid", out_valid, 1);
      chk("after_bubble_alu_a", alu_a, 9);
      chk("after_bubble_dest", dest_reg, 6);
      tick();
      // backpressure refresh
      in_valid = 1; in_rt = 7; in_rt_data = 1;
      tick();
      clr();
      out_ready = 0;
      exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h1234;
      #1;
      chk("bp_c1_store", store_data, 32'h1234);
      tick();
      exmem_reg_write = 0;
      #1;
      chk("bp_c2_store", store_data, 32'h1234);
      tick();
      chk("bp_c3_store", store_data, 32'h1234);
      chk("bp_c3_valid", out_valid, 1);
      out_ready = 1;
      #1;
      chk("bp_xfer_store", store_data, 32'h1234);
      tick();
      chk("bp_drained", out_valid, 0);
      // flush beats capture and hazard
      in_valid = 1; in_mem_read = 1; in_rt = 4; in_rs = 1; in_rs_data = 32'h33;
      tick();
      clr();
      in_valid = 1; in_rs = 4; in_rs_data = 32'h77; flush = 1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      tick();
      clr();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_no_stall", stall_cnt, 1);
      chk("flush_dropped", alu_a, 32'h33);
      // reset mid-hold
      in_valid = 1; in_rs = 2; in_rs_data = 32'h55; in_reg_write = 1;
      tick();
      clr();
      out_ready = 0;
      tick();
      chk("hold_valid", out_valid, 1);
      rst = 1;
      tick();
      chk("rst_hold_valid", out_valid, 0);
      chk("rst_hold_stall", stall_cnt, 0);
      chk("rst_hold_alu_a", alu_a, 0);
      rst = 0; out_ready = 1;
      tick();
      chk("no_reissue_valid", out_valid, 0);
      chk("no_reissue_reg_write", out_reg_write, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
